// File: rtl/sirv_rtc_mc.sv
// Real-time counter with prescaled compare channels and per-channel interrupt pending bits.
// The wide count splits into two 32-bit fields for register access; s is the shifted view.
module sirv_rtc_mc #(
  parameter int CNT_W   = 48,
  parameter int NCMP    = 2,
  parameter int SCALE_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_regs_cfg_write_valid,
  input  logic [31:0]          io_regs_cfg_write_bits,
  output logic [31:0]          io_regs_cfg_read,
  input  logic                 io_regs_countLo_write_valid,
  input  logic [31:0]          io_regs_countLo_write_bits,
  output logic [31:0]          io_regs_countLo_read,
  input  logic                 io_regs_countHi_write_valid,
  input  logic [31:0]          io_regs_countHi_write_bits,
  output logic [31:0]          io_regs_countHi_read,
  output logic [31:0]          io_regs_s_read,
  input  logic [NCMP-1:0]      io_regs_cmp_write_valid,
  input  logic [32*NCMP-1:0]   io_regs_cmp_write_bits,
  output logic [32*NCMP-1:0]   io_regs_cmp_read,
  input  logic                 io_regs_ip_write_valid,
  input  logic [31:0]          io_regs_ip_write_bits,
  output logic [NCMP-1:0]      io_ip
);

  localparam int HI_W = CNT_W - 32;

  logic [CNT_W-1:0]   count_q, count_d;
  logic [SCALE_W-1:0] scale_q, scale_d;
  logic               count_always_q, count_always_d;
  logic               zerocmp_q, zerocmp_d;
  logic               sticky_q, sticky_d;
  logic [31:0]        cmp_q [NCMP];
  logic [31:0]        cmp_d [NCMP];
  logic [NCMP-1:0]    ip_q, ip_d;
  logic [NCMP-1:0]    elapsed;
  logic [CNT_W-1:0]   count_shifted;
  logic [31:0]        s;

  assign count_shifted = count_q >> scale_q;
  assign s             = count_shifted[31:0];

  assign scale_d        = io_regs_cfg_write_valid ? io_regs_cfg_write_bits[SCALE_W-1:0] : scale_q;
  assign count_always_d = io_regs_cfg_write_valid ? io_regs_cfg_write_bits[12] : count_always_q;
  assign zerocmp_d      = io_regs_cfg_write_valid ? io_regs_cfg_write_bits[13] : zerocmp_q;
  assign sticky_d       = io_regs_cfg_write_valid ? io_regs_cfg_write_bits[14] : sticky_q;

  // Software writes win over both the increment and the zerocmp wrap.
  always_comb begin
    count_d = count_q;
    if (io_regs_countLo_write_valid || io_regs_countHi_write_valid) begin
      if (io_regs_countLo_write_valid) count_d[31:0] = io_regs_countLo_write_bits;
      if (io_regs_countHi_write_valid) count_d[CNT_W-1:32] = io_regs_countHi_write_bits[HI_W-1:0];
    end else if (count_always_q) begin
      if (zerocmp_q && elapsed[0]) count_d = '0;
      else                         count_d = count_q + CNT_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < NCMP; gi++) begin : g_chan
      assign elapsed[gi] = (s >= cmp_q[gi]);
      assign cmp_d[gi]   = io_regs_cmp_write_valid[gi] ? io_regs_cmp_write_bits[32*gi +: 32] : cmp_q[gi];
      // In sticky mode a same-cycle set beats the write-1-to-clear.
      assign ip_d[gi]    = sticky_q
                           ? (elapsed[gi] | (ip_q[gi] & ~(io_regs_ip_write_valid & io_regs_ip_write_bits[gi])))
                           : elapsed[gi];
      assign io_regs_cmp_read[32*gi +: 32] = cmp_q[gi];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          cmp_q[gi] <= 32'hFFFF_FFFF;
          ip_q[gi]  <= 1'b0;
        end else begin
          cmp_q[gi] <= cmp_d[gi];
          ip_q[gi]  <= ip_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q        <= '0;
      scale_q        <= '0;
      count_always_q <= 1'b0;
      zerocmp_q      <= 1'b0;
      sticky_q       <= 1'b0;
    end else begin
      count_q        <= count_d;
      scale_q        <= scale_d;
      count_always_q <= count_always_d;
      zerocmp_q      <= zerocmp_d;
      sticky_q       <= sticky_d;
    end
  end

  always_comb begin
    io_regs_cfg_read                = '0;
    io_regs_cfg_read[SCALE_W-1:0]   = scale_q;
    io_regs_cfg_read[12]            = count_always_q;
    io_regs_cfg_read[13]            = zerocmp_q;
    io_regs_cfg_read[14]            = sticky_q;
    for (int i = 0; i < NCMP; i++) io_regs_cfg_read[28+i] = ip_q[i];
  end

  always_comb begin
    io_regs_countHi_read           = '0;
    io_regs_countHi_read[HI_W-1:0] = count_q[CNT_W-1:32];
  end

  assign io_regs_countLo_read = count_q[31:0];
  assign io_regs_s_read       = s;
  assign io_ip                = ip_q;

endmodule

// File: tb/tb_sirv_rtc_mc.sv
// Randomized and directed bench for sirv_rtc_mc against an arithmetic reference model.
module tb_sirv_rtc_mc;
  localparam int CNT_W   = 48;
  localparam int NCMP    = 2;
  localparam int SCALE_W = 4;
  localparam longint unsigned MOD  = 64'd1 << CNT_W;
  localparam longint unsigned TWO32 = 64'd1 << 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic                cfg_wv = 0, lo_wv = 0, hi_wv = 0, ip_wv = 0;
  logic [31:0]         cfg_wb = 0, lo_wb = 0, hi_wb = 0, ip_wb = 0;
  logic [NCMP-1:0]     cmp_wv = '0;
  logic [32*NCMP-1:0]  cmp_wb = '0;
  logic [31:0]         cfg_rd, lo_rd, hi_rd, s_rd;
  logic [32*NCMP-1:0]  cmp_rd;
  logic [NCMP-1:0]     ip_o;

  sirv_rtc_mc #(.CNT_W(CNT_W), .NCMP(NCMP), .SCALE_W(SCALE_W)) dut (
    .clock(clock), .reset(reset),
    .io_regs_cfg_write_valid(cfg_wv), .io_regs_cfg_write_bits(cfg_wb), .io_regs_cfg_read(cfg_rd),
    .io_regs_countLo_write_valid(lo_wv), .io_regs_countLo_write_bits(lo_wb), .io_regs_countLo_read(lo_rd),
    .io_regs_countHi_write_valid(hi_wv), .io_regs_countHi_write_bits(hi_wb), .io_regs_countHi_read(hi_rd),
    .io_regs_s_read(s_rd),
    .io_regs_cmp_write_valid(cmp_wv), .io_regs_cmp_write_bits(cmp_wb), .io_regs_cmp_read(cmp_rd),
    .io_regs_ip_write_valid(ip_wv), .io_regs_ip_write_bits(ip_wb),
    .io_ip(ip_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: count as a plain integer modulo 2^CNT_W.
  longint unsigned m_count;
  int unsigned     m_scale;
  bit              m_ca, m_zc, m_st;
  int unsigned     m_cmp [NCMP];
  logic [NCMP-1:0] m_ip;

  function automatic longint unsigned m_s();
    return (m_count >> m_scale) % TWO32;
  endfunction

  task automatic model_reset();
    m_count = 0; m_scale = 0; m_ca = 0; m_zc = 0; m_st = 0; m_ip = '0;
    for (int i = 0; i < NCMP; i++) m_cmp[i] = 32'hFFFF_FFFF;
  endtask

  task automatic check_all();
    longint unsigned exp_cfg;
    exp_cfg = m_scale + (longint'(m_ca) << 12) + (longint'(m_zc) << 13) + (longint'(m_st) << 14)
              + (longint'(m_ip) << 28);
    check_eq("countLo", lo_rd, m_count % TWO32);
    check_eq("countHi", hi_rd, m_count / TWO32);
    check_eq("s", s_rd, m_s());
    check_eq("io_ip", ip_o, m_ip);
    check_eq("cfg", cfg_rd, exp_cfg);
    for (int i = 0; i < NCMP; i++) check_eq("cmp", cmp_rd[32*i +: 32], m_cmp[i]);
  endtask

  // One clock: evaluate the model on current inputs, take the edge, commit, check.
  task automatic step();
    longint unsigned s, n_count, lo, hi;
    logic [NCMP-1:0] el, n_ip;
    s = m_s();
    for (int i = 0; i < NCMP; i++) el[i] = (s >= m_cmp[i]);
    n_count = m_count;
    if (lo_wv || hi_wv) begin
      lo = lo_wv ? longint'(lo_wb) : m_count % TWO32;
      hi = hi_wv ? longint'(hi_wb) % (MOD / TWO32) : m_count / TWO32;
      n_count = hi * TWO32 + lo;
    end else if (m_ca) begin
      n_count = (m_zc && el[0]) ? 0 : (m_count + 1) % MOD;
    end
    for (int i = 0; i < NCMP; i++)
      n_ip[i] = m_st ? (el[i] || (m_ip[i] && !(ip_wv && ip_wb[i]))) : el[i];
    @(posedge clock);
    #1;
    m_count = n_count;
    m_ip = n_ip;
    if (cfg_wv) begin
      m_scale = cfg_wb % (1 << SCALE_W);
      m_ca = cfg_wb[12]; m_zc = cfg_wb[13]; m_st = cfg_wb[14];
    end
    for (int i = 0; i < NCMP; i++) if (cmp_wv[i]) m_cmp[i] = cmp_wb[32*i +: 32];
    cfg_wv = 0; lo_wv = 0; hi_wv = 0; ip_wv = 0; cmp_wv = '0;
    check_all();
  endtask

  task automatic wr_cfg(input logic [31:0] v);
    $display("cfg write %08h", v);
    cfg_wv = 1; cfg_wb = v; step();
  endtask

  task automatic wr_count(input logic [31:0] lo, input logic [31:0] hi);
    $display("count write hi=%08h lo=%08h", hi, lo);
    lo_wv = 1; lo_wb = lo; hi_wv = 1; hi_wb = hi; step();
  endtask

  task automatic wr_cmp(input int ch, input logic [31:0] v);
    $display("cmp%0d write %08h", ch, v);
    cmp_wv[ch] = 1'b1; cmp_wb[32*ch +: 32] = v; step();
  endtask

  task automatic wr_ip(input logic [31:0] v);
    $display("ip clear write %08h", v);
    ip_wv = 1; ip_wb = v; step();
  endtask

  task automatic async_reset_check();
    @(posedge clock);
    #3 reset = 1;
    #1;
    $display("async reset asserted");
    model_reset();
    check_eq("rst_ip", ip_o, 0);
    check_eq("rst_cfg", cfg_rd, 0);
    check_eq("rst_s", s_rd, 0);
    check_eq("rst_lo", lo_rd, 0);
    check_eq("rst_hi", hi_rd, 0);
    for (int i = 0; i < NCMP; i++) check_eq("rst_cmp", cmp_rd[32*i +: 32], 32'hFFFF_FFFF);
    @(posedge clock);
    #1 reset = 0;
    check_all();
  endtask

  initial begin
    int pulses;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 0;
    check_eq("rst_cmp0", cmp_rd[31:0], 32'hFFFF_FFFF);
    check_eq("rst_cnt", lo_rd, 0);
    check_all();

    // Free-running count, scale 0.
    wr_cfg(32'h0000_1000);
    repeat (5) step();

    // Carry from low into high field, then full-width wrap.
    wr_cfg(32'h0);
    wr_count(32'hFFFF_FFFF, 32'h0);
    wr_cfg(32'h0000_1000);
    step();
    check_eq("carry_hi", hi_rd, 1);
    check_eq("carry_lo", lo_rd, 0);
    wr_count(32'hFFFF_FFFF, 32'h0000_FFFF);
    step();
    check_eq("wrap_lo", lo_rd, 0);
    check_eq("wrap_hi", hi_rd, 0);

    // Prescaled compare on channel 1.
    wr_cfg(32'h0);
    wr_count(32'h0, 32'h0);
    wr_cmp(1, 32'd4);
    wr_cfg(32'h0000_1003);
    for (int k = 0; k < 40 && lo_rd != 32; k++) step();
    check_eq("scaled_cnt", lo_rd, 32);
    check_eq("scaled_s", s_rd, 4);
    check_eq("scaled_ip_pre", ip_o, 2'b00);
    step();
    check_eq("scaled_ip1", ip_o[1], 1);
    check_eq("scaled_ip0", ip_o[0], 0);

    // Sticky pending survives compare move until cleared.
    wr_cfg(32'h0);
    wr_count(32'h0, 32'h0);
    wr_cmp(1, 32'hFFFF_FFFF);
    wr_cmp(0, 32'd10);
    wr_cfg(32'h0000_5000);
    repeat (14) step();
    wr_cmp(0, 32'hFFFF_FFFF);
    repeat (3) step();
    check_eq("sticky_hold", ip_o[0], 1);
    wr_ip(32'h1);
    check_eq("sticky_clr", ip_o[0], 0);

    // Zero-on-compare period of 6.
    wr_cfg(32'h0);
    wr_count(32'h0, 32'h0);
    wr_cmp(0, 32'd5);
    wr_cfg(32'h0000_3000);
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_eq("zc_seq", lo_rd, k % 6);
      if (ip_o[0]) pulses++;
    end
    check_eq("zc_pulses", pulses, 2);

    // Randomized traffic.
    wr_cfg(32'h0);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) < 4) begin
        cfg_wv = 1;
        cfg_wb = $urandom & 32'hF000_F00F;
        cfg_wb[3:0] = 4'($urandom_range(0, 6));
        if ($urandom_range(0, 3) == 0) cfg_wb[3:0] = 4'($urandom);
      end
      if ($urandom_range(0, 99) < 4) begin
        lo_wv = 1;
        lo_wb = ($urandom_range(0, 1) == 1) ? $urandom : 32'hFFFF_FFF0 + $urandom_range(0, 15);
      end
      if ($urandom_range(0, 99) < 4) begin
        hi_wv = 1;
        hi_wb = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0000_FFFF;
      end
      for (int i = 0; i < NCMP; i++)
        if ($urandom_range(0, 99) < 5) begin
          cmp_wv[i] = 1'b1;
          cmp_wb[32*i +: 32] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 80);
        end
      if ($urandom_range(0, 99) < 8) begin
        ip_wv = 1;
        ip_wb = $urandom;
      end
      step();
    end

    // Reset mid-count with a pending interrupt.
    wr_cfg(32'h0);
    wr_count(32'h0, 32'h0);
    wr_cmp(0, 32'h0);
    wr_cfg(32'h0000_1000);
    step();
    check_eq("pre_rst_ip", ip_o[0], 1);
    async_reset_check();
    repeat (5) step();
    check_eq("post_rst_cnt", lo_rd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sirv_rtc_mc.md
SIRV_RTC_MC -- requirements
Module: sirv_rtc_mc

Interface
REQ-001 The block SHALL have parameter CNT_W, default 48, meaning counter width; legal range 33..64.
REQ-002 The block SHALL have parameter NCMP, default 2, meaning comparator/interrupt channel count; legal range 1..4.
REQ-003 The block SHALL have parameter SCALE_W, default 4, meaning width of the prescale shift field; legal range 1..5.
REQ-004 Port list (name  direction  width  meaning):
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- io_regs_cfg_write_valid  in  1  cfg write strobe.
- io_regs_cfg_write_bits  in  32  cfg write data.
- io_regs_cfg_read  out  32  cfg readback.
- io_regs_countLo_write_valid / _bits / _read  in/in/out  1/32/32  count[31:0] access.
- io_regs_countHi_write_valid / _bits / _read  in/in/out  1/32/32  count[CNT_W-1:32] access, zero-extended on read.
- io_regs_s_read  out  32  scaled count.
- io_regs_cmp_write_valid  in  NCMP  per-channel compare write strobe.
- io_regs_cmp_write_bits  in  32*NCMP  compare data; channel i at [32i+31:32i].
- io_regs_cmp_read  out  32*NCMP  compare readback.
- io_regs_ip_write_valid  in  1  pending-clear strobe.
- io_regs_ip_write_bits  in  32  write-1-to-clear mask, bit i = channel i.
- io_ip  out  NCMP  interrupt pending per channel.

Function
REQ-005 cfg layout SHALL be: [SCALE_W-1:0] scale, [12] countAlways, [13] zerocmp, [14] sticky, [28+i] ip_i (read-only), all other bits read 0.
REQ-006 A cfg write SHALL update scale, countAlways, zerocmp and sticky on the next clock edge; written ip bits SHALL be ignored.
REQ-007 count SHALL be a CNT_W-bit register that increments by 1 per cycle while countAlways=1 and wraps from all-ones to 0.
REQ-008 A countLo write SHALL replace count[31:0], and a countHi write SHALL replace count[CNT_W-1:32] with the low CNT_W-32 bits of the write data.
REQ-009 A countLo write and a countHi write in the same cycle SHALL each load their own field; the increment SHALL be suppressed in that cycle.
REQ-010 A single-field write SHALL leave the other field holding its current value, with no increment and no carry applied.
REQ-011 s SHALL equal (count >> scale)[31:0], combinational from the registered count and scale.
REQ-012 elapsed_i SHALL equal (s >= cmp_i) as an unsigned 32-bit comparison.
REQ-013 With sticky=0, ip_i SHALL be registered elapsed_i, one cycle latency.
REQ-014 With sticky=1, ip_i SHALL set when elapsed_i=1 and clear only on an ip write with bit i=1.
REQ-015 With sticky=1, a set and a clear of ip_i in the same cycle SHALL leave ip_i=1.
REQ-016 With zerocmp=1, countAlways=1 and elapsed_0=1, the next count SHALL be 0 instead of count+1.
REQ-017 A software count write SHALL take priority over the zerocmp clear.
REQ-018 A cmp_i write SHALL take effect on the next edge, and ip_i SHALL reflect the new compare one cycle after that.
REQ-019 io_ip SHALL equal the ip register vector, with no combinational path from any input.

Reset
REQ-020 On reset assertion, asynchronously: count=0, scale=0, countAlways=0, zerocmp=0, sticky=0, every cmp_i=32'hFFFF_FFFF, every ip_i=0.
REQ-021 Reset output values SHALL be: io_ip=0, io_regs_cfg_read=0, io_regs_s_read=0, count reads=0, and each cmp read=32'hFFFF_FFFF.
REQ-022 Reset asserted mid-count SHALL clear all state immediately, with counting resumed only after a new cfg write.

Verification
REQ-023 Write cfg=0x1000, scale 0 -> countLo read advances by 1 per cycle, s tracks countLo, io_ip=0.
REQ-024 Write countLo=0xFFFF_FFFF, countHi=0, countAlways=1 -> after one increment countHi=1, countLo=0; with count at all-ones over CNT_W, the counter wraps to 0.
REQ-025 Write scale=3, cmp_1=4, countAlways=1 from count 0 -> s reaches 4 at count 32, io_ip[1] rises one cycle later, io_ip[0] stays 0.
REQ-026 Set sticky=1, cmp_0=10, run past 10, then write cmp_0=0xFFFF_FFFF -> ip_0 stays 1 until an ip write of 0x1, then drops to 0.
REQ-027 Set zerocmp=1, cmp_0=5, countAlways=1 -> count sequence 0,1,2,3,4,5,0,1,...; ip_0 pulses once per period when sticky=0.
REQ-028 Assert reset while counting with io_ip=1 -> all outputs take their REQ-021 values in the same cycle, and count stays 0 after release.
